reg_writeback_queue: RTL and testbench
======================================

Name: reg_writeback_queue

Overview:
Write-side front end for the 24-entry x 32-bit register file. It accepts register write requests from two producers, the ALU and the load/store unit (LSU), and buffers them in an in-order queue. It drains one write per cycle into the register file's single write port (write_enable / write_address / data_in). It also offers two combinational lookup ports so that decode can forward not-yet-written results and detect pending destinations.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
NREGS, 24, number of architectural registers; valid addresses are 0..NREGS-1
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous, active-low
alu_valid  in  1  ALU write request
alu_ready  out  1  ALU request accepted this cycle
alu_addr  in  AW  ALU destination register
alu_data  in  DW  ALU result
lsu_valid  in  1  LSU write request
lsu_ready  out  1  LSU request accepted this cycle
lsu_addr  in  AW  LSU destination register
lsu_data  in  DW  load data
wr_hold  in  1  register file busy; hold the drain
write_enable  out  1  to register file write_enable
write_address  out  AW  to register file write_address
data_in  out  DW  to register file data_in
q_addr1  in  AW  lookup address 1
q_addr2  in  AW  lookup address 2
q_hit1  out  1  a queued entry targets q_addr1
q_hit2  out  1  a queued entry targets q_addr2
q_data1  out  DW  data of the youngest matching entry for q_addr1
q_data2  out  DW  data of the youngest matching entry for q_addr2
level  out  clog2(DEPTH)+1  current occupancy
full  out  1  level == DEPTH
empty  out  1  level == 0

Behaviour:
- Reset: asynchronous, active-low.
  - While rst_n is low: level=0, empty=1, full=0, write_enable=0, write_address=0, data_in=0, q_hit1=q_hit2=0, q_data1=q_data2=0.
  - All queued contents are discarded, including a reset mid-drain.
- Storage: circular buffer with rd_ptr and wr_ptr. Pointers wrap modulo DEPTH; the count is held separately.
- Drain side:
  - write_enable = !empty && !wr_hold. This is combinational from registered state.
  - write_address and data_in are the head entry when non-empty, otherwise 0.
  - When write_enable=1, the head is popped at the clock edge.
  - Latency: a request accepted at edge N appears on the write port in cycle N+1, provided the queue was empty and wr_hold is low.
- Enqueue side:
  - free = DEPTH - level + (write_enable ? 1 : 0). A same-cycle pop frees a slot, so a full queue with write_enable=1 still accepts one request.
  - alu_ready = (free >= 1).
  - lsu_ready = (free >= 2) || (free == 1 && !alu_valid). When only one slot is free, the ALU has priority.
  - When both producers are accepted in the same cycle, the ALU entry is enqueued first (older) and the LSU entry second (younger).
- Out-of-range address (addr >= NREGS):
  - The request is accepted (ready follows the rules above) but is not enqueued and consumes no slot.
  - The register file would ignore such a write anyway.
  - For free-slot accounting, a dropped request still counts toward the ALU priority rule.
- Address 0 is an ordinary writable register; it is not hardwired.
- Lookups are combinational:
  - q_hitK = 1 if any valid entry has addr == q_addrK.
  - q_dataK = data of the youngest such entry; 0 if there is no hit.
  - Same-cycle incoming requests are not visible to lookups.
  - An entry being popped this cycle still counts as a hit.
  - q_addrK >= NREGS always gives a miss.
- Same-address ordering: writes reach the register file in enqueue order, so the final register value is the youngest write.
- level changes by (number enqueued) - (1 if popped); the result is always in 0..DEPTH.
- No internal state machine beyond the pointers and count. The drain is in one of two modes:
  - IDLE when empty.
  - DRAIN when non-empty, stalling in place while wr_hold=1.

Test Plan:
- Reset and single write: release rst_n, then pulse alu_valid for one cycle with addr=5, data=0x11. In the next cycle write_enable=1, write_address=5, data_in=0x11; the cycle after, empty=1.
- Dual accept and ordering: alu (3, 0xA) and lsu (3, 0xB) in the same cycle with the queue empty. q_hit on address 3 returns 0xB. Writes drain as 0xA then 0xB on consecutive cycles.
- Full with simultaneous pop:
  - Hold wr_hold=1 and fill 4 entries: full=1 and alu_ready=0.
  - Drop wr_hold and present both producers: alu_ready=1, lsu_ready=0, level stays 4.
- Hold and wrap-around: with wr_hold=1, enqueue 3, drain 2, then enqueue 3 more so the pointers wrap. Drain order matches enqueue order exactly; level reaches 4, then 0.
- Out-of-range: alu_addr=30 with alu_valid=1. alu_ready=1, level unchanged, no write_enable pulse, and q_addr1=30 reports a miss.
- Reset mid-operation: with 3 entries queued, assert rst_n low between clock edges. Outputs clear immediately; after release, empty=1 and no stale writes appear.

Source files
------------

// File: rtl/reg_writeback_queue_if.sv
// Handshake/bus bundle for reg_writeback_queue.
//   producers : alu_* and lsu_* request/accept, wr_hold from the register file
//   drain     : write_enable / write_address / data_in to the register file
//   lookup    : q_addrK in, q_hitK / q_dataK out for decode forwarding
//   status    : level / full / empty
// master = producer/register-file side, slave = the queue.
interface reg_writeback_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_data;
    logic          wr_hold;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [DW-1:0] data_in;
    logic [AW-1:0] q_addr1;
    logic [AW-1:0] q_addr2;
    logic          q_hit1;
    logic          q_hit2;
    logic [DW-1:0] q_data1;
    logic [DW-1:0] q_data2;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        output wr_hold, q_addr1, q_addr2,
        input  alu_ready, lsu_ready,
        input  write_enable, write_address, data_in,
        input  q_hit1, q_hit2, q_data1, q_data2,
        input  level, full, empty
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        input  wr_hold, q_addr1, q_addr2,
        output alu_ready, lsu_ready,
        output write_enable, write_address, data_in,
        output q_hit1, q_hit2, q_data1, q_data2,
        output level, full, empty
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order write-back queue in front of the register file's single write port.
// Accepts writes from ALU and LSU (ALU wins a lone free slot, ALU is older on a
// dual accept), drains one entry per cycle unless wr_hold, and offers two
// combinational lookups returning the youngest queued write to an address.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards all queued writes
//   bus   : reg_writeback_queue_if.slave (request, drain, lookup, status)
module reg_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NREGS = 24,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reg_writeback_queue_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned FW = LW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] count_q, count_d;

    logic          empty_c;
    logic          pop_c;
    logic [FW-1:0] free_c;
    logic          alu_ready_c;
    logic          lsu_ready_c;
    logic          alu_push_c;
    logic          lsu_push_c;
    logic [PW-1:0] lsu_slot_c;

    // Drain: head goes out whenever something is queued and the file is not busy.
    assign empty_c = (count_q == '0);
    assign pop_c   = !empty_c && !bus.wr_hold;

    // A same-cycle pop frees a slot, so a full queue can still take one request.
    assign free_c      = FW'(DEPTH) - FW'(count_q) + FW'(pop_c);
    assign alu_ready_c = (free_c >= FW'(1));
    assign lsu_ready_c = (free_c >= FW'(2)) || ((free_c == FW'(1)) && !bus.alu_valid);

    // Out-of-range destinations are accepted but never stored.
    assign alu_push_c = bus.alu_valid && alu_ready_c && (32'(bus.alu_addr) < NREGS);
    assign lsu_push_c = bus.lsu_valid && lsu_ready_c && (32'(bus.lsu_addr) < NREGS);
    assign lsu_slot_c = alu_push_c ? (wr_ptr_q + PW'(1)) : wr_ptr_q;

    // Next-state pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        wr_ptr_d = wr_ptr_q + PW'(alu_push_c) + PW'(lsu_push_c);
        count_d  = count_q + LW'(alu_push_c) + LW'(lsu_push_c) - LW'(pop_c);
    end

    // State and storage; ALU entry lands first so it is older than the LSU entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (alu_push_c) begin
                addr_q[wr_ptr_q] <= bus.alu_addr;
                data_q[wr_ptr_q] <= bus.alu_data;
            end
            if (lsu_push_c) begin
                addr_q[lsu_slot_c] <= bus.lsu_addr;
                data_q[lsu_slot_c] <= bus.lsu_data;
            end
        end
    end

    // Forwarding lookups: walk oldest to youngest so the youngest match wins.
    // Stored addresses are always in range, so an out-of-range query never hits.
    logic [PW-1:0] idx_c;
    logic          hit1_c, hit2_c;
    logic [DW-1:0] fwd1_c, fwd2_c;

    always_comb begin
        idx_c  = '0;
        hit1_c = 1'b0;
        hit2_c = 1'b0;
        fwd1_c = '0;
        fwd2_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx_c = rd_ptr_q + PW'(i);
            if (LW'(i) < count_q) begin
                if (addr_q[idx_c] == bus.q_addr1) begin
                    hit1_c = 1'b1;
                    fwd1_c = data_q[idx_c];
                end
                if (addr_q[idx_c] == bus.q_addr2) begin
                    hit2_c = 1'b1;
                    fwd2_c = data_q[idx_c];
                end
            end
        end
    end

    assign bus.alu_ready     = alu_ready_c;
    assign bus.lsu_ready     = lsu_ready_c;
    assign bus.write_enable  = pop_c;
    assign bus.write_address = empty_c ? '0 : addr_q[rd_ptr_q];
    assign bus.data_in       = empty_c ? '0 : data_q[rd_ptr_q];
    assign bus.q_hit1        = hit1_c;
    assign bus.q_hit2        = hit2_c;
    assign bus.q_data1       = fwd1_c;
    assign bus.q_data2       = fwd2_c;
    assign bus.level         = count_q;
    assign bus.full          = (count_q == LW'(DEPTH));
    assign bus.empty         = empty_c;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: queue-based reference model plus directed
// scenarios with literal expectations.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;
    localparam int NREGS = 24;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;
    ent_t mq[$];

    reg_writeback_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) ifc ();

    reg_writeback_queue #(.DEPTH(DEPTH), .NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_we();
        return (mq.size() != 0) && !ifc.wr_hold;
    endfunction

    function automatic int m_free();
        return DEPTH - mq.size() + (m_we() ? 1 : 0);
    endfunction

    function automatic bit m_lsu_ready();
        int f = m_free();
        return (f >= 2) || (f == 1 && !ifc.alu_valid);
    endfunction

    function automatic void m_lookup(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        foreach (mq[i]) begin
            if (mq[i].a == a && int'(a) < NREGS) begin
                h = 1'b1;
                d = mq[i].d;
            end
        end
    endfunction

    function automatic void m_step();
        bit we = m_we();
        bit ar = (m_free() >= 1);
        bit lr = m_lsu_ready();
        if (we) void'(mq.pop_front());
        if (ifc.alu_valid && ar && int'(ifc.alu_addr) < NREGS) mq.push_back({ifc.alu_addr, ifc.alu_data});
        if (ifc.lsu_valid && lr && int'(ifc.lsu_addr) < NREGS) mq.push_back({ifc.lsu_addr, ifc.lsu_data});
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mq.delete();
        else        m_step();
    end

    // Per-cycle comparison of every output against the model.
    task automatic cmp_cycle();
        logic          h1, h2;
        logic [DW-1:0] d1, d2;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        m_lookup(ifc.q_addr1, h1, d1);
        m_lookup(ifc.q_addr2, h2, d2);
        ea = (mq.size() != 0) ? mq[0].a : '0;
        ed = (mq.size() != 0) ? mq[0].d : '0;
        chk("write_enable",  32'(ifc.write_enable),  32'(m_we()));
        chk("write_address", 32'(ifc.write_address), 32'(ea));
        chk("data_in",       ifc.data_in,            ed);
        chk("alu_ready",     32'(ifc.alu_ready),     32'(m_free() >= 1));
        chk("lsu_ready",     32'(ifc.lsu_ready),     32'(m_lsu_ready()));
        chk("level",         32'(ifc.level),         32'(mq.size()));
        chk("full",          32'(ifc.full),          32'(mq.size() == DEPTH));
        chk("empty",         32'(ifc.empty),         32'(mq.size() == 0));
        chk("q_hit1",        32'(ifc.q_hit1),        32'(h1));
        chk("q_data1",       ifc.q_data1,            d1);
        chk("q_hit2",        32'(ifc.q_hit2),        32'(h2));
        chk("q_data2",       ifc.q_data2,            d2);
    endtask

    always @(negedge clk) cmp_cycle();

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifc.alu_valid = v;
        ifc.alu_addr  = a;
        ifc.alu_data  = d;
    endtask

    task automatic lsu(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifc.lsu_valid = v;
        ifc.lsu_addr  = a;
        ifc.lsu_data  = d;
    endtask

    task automatic idle();
        alu(1'b0, '0, '0);
        lsu(1'b0, '0, '0);
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) begin
            if (ifc.empty) break;
            cyc();
            #2;
        end
        chk("drain_done", 32'(ifc.empty), 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        ifc.wr_hold = 1'b0;
        ifc.q_addr1 = '0;
        ifc.q_addr2 = '0;
        #2;
        chk("rst_level", 32'(ifc.level), 32'd0);
        chk("rst_empty", 32'(ifc.empty), 32'd1);
        chk("rst_we",    32'(ifc.write_enable), 32'd0);
        #10 rst_n = 1'b1;

        // single ALU write: visible on the write port one cycle later
        cyc(); alu(1'b1, 5'd5, 32'h11); #2;
        chk("t1_alu_ready", 32'(ifc.alu_ready), 32'd1);
        cyc(); idle(); #2;
        chk("t1_we",   32'(ifc.write_enable),  32'd1);
        chk("t1_addr", 32'(ifc.write_address), 32'd5);
        chk("t1_data", ifc.data_in,            32'h11);
        cyc(); #2;
        chk("t1_empty", 32'(ifc.empty), 32'd1);

        // dual accept to the same register: ALU older, LSU younger
        cyc(); alu(1'b1, 5'd3, 32'hA); lsu(1'b1, 5'd3, 32'hB); ifc.q_addr1 = 5'd3; ifc.q_addr2 = 5'd4; #2;
        chk("t2_miss_before", 32'(ifc.q_hit1), 32'd0);
        cyc(); idle(); #2;
        chk("t2_hit",    32'(ifc.q_hit1), 32'd1);
        chk("t2_fwd",    ifc.q_data1,     32'hB);
        chk("t2_miss2",  32'(ifc.q_hit2), 32'd0);
        chk("t2_first",  ifc.data_in,     32'hA);
        cyc(); #2;
        chk("t2_second", ifc.data_in,     32'hB);
        chk("t2_popping_hit", 32'(ifc.q_hit1), 32'd1);
        cyc(); #2;
        chk("t2_empty", 32'(ifc.empty), 32'd1);

        // fill under hold, then full with a simultaneous pop
        ifc.q_addr1 = 5'd2; ifc.q_addr2 = 5'd8;
        for (int i = 1; i <= 4; i++) begin
            cyc(); ifc.wr_hold = 1'b1; alu(1'b1, 5'(i), 32'h100 + 32'(i));
        end
        cyc(); idle(); #2;
        chk("t3_full",      32'(ifc.full),      32'd1);
        chk("t3_alu_ready", 32'(ifc.alu_ready), 32'd0);
        chk("t3_level",     32'(ifc.level),     32'd4);
        chk("t3_fwd",       ifc.q_data1,        32'h102);
        cyc(); ifc.wr_hold = 1'b0; alu(1'b1, 5'd7, 32'h77); lsu(1'b1, 5'd8, 32'h88); #2;
        chk("t3_alu_rdy_pop", 32'(ifc.alu_ready), 32'd1);
        chk("t3_lsu_rdy_pop", 32'(ifc.lsu_ready), 32'd0);
        chk("t3_head",        ifc.data_in,        32'h101);
        cyc(); idle(); #2;
        chk("t3_level_kept",  32'(ifc.level),     32'd4);
        chk("t3_lsu_dropped", 32'(ifc.q_hit2),    32'd0);
        drain();

        // hold and pointer wrap-around
        cyc(); ifc.wr_hold = 1'b1; alu(1'b1, 5'd10, 32'h210);
        cyc(); alu(1'b1, 5'd11, 32'h211);
        cyc(); alu(1'b1, 5'd12, 32'h212);
        cyc(); idle(); ifc.wr_hold = 1'b0; #2;
        chk("t4_d0", ifc.data_in, 32'h210);
        cyc(); #2;
        chk("t4_d1", ifc.data_in, 32'h211);
        cyc(); ifc.wr_hold = 1'b1; alu(1'b1, 5'd13, 32'h213); #2;
        chk("t4_level1", 32'(ifc.level), 32'd1);
        cyc(); alu(1'b1, 5'd14, 32'h214);
        cyc(); alu(1'b1, 5'd15, 32'h215);
        cyc(); idle(); #2;
        chk("t4_level4", 32'(ifc.level), 32'd4);
        chk("t4_held_we", 32'(ifc.write_enable), 32'd0);
        cyc(); ifc.wr_hold = 1'b0; #2;
        chk("t4_d2", ifc.data_in, 32'h212);
        cyc(); #2;
        chk("t4_d3", ifc.data_in, 32'h213);
        drain();
        chk("t4_level0", 32'(ifc.level), 32'd0);

        // out-of-range destination is accepted and dropped; address 0 is writable
        cyc(); alu(1'b1, 5'd30, 32'hDEAD); ifc.q_addr1 = 5'd30; #2;
        chk("t5_alu_ready", 32'(ifc.alu_ready), 32'd1);
        cyc(); idle(); #2;
        chk("t5_level", 32'(ifc.level),        32'd0);
        chk("t5_no_we", 32'(ifc.write_enable), 32'd0);
        chk("t5_miss",  32'(ifc.q_hit1),       32'd0);
        cyc(); alu(1'b1, 5'd0, 32'h55); ifc.q_addr1 = 5'd0;
        cyc(); idle(); #2;
        chk("t5_r0_we",   32'(ifc.write_enable),  32'd1);
        chk("t5_r0_addr", 32'(ifc.write_address), 32'd0);
        chk("t5_r0_fwd",  ifc.q_data1,            32'h55);
        cyc(); #2;

        // reset between edges with entries queued
        cyc(); ifc.wr_hold = 1'b1; alu(1'b1, 5'd20, 32'h320);
        cyc(); alu(1'b1, 5'd21, 32'h321);
        cyc(); alu(1'b0, '0, '0); lsu(1'b1, 5'd22, 32'h322);
        cyc(); idle(); ifc.q_addr1 = 5'd21; #2;
        chk("t6_level3", 32'(ifc.level),  32'd3);
        chk("t6_hit",    32'(ifc.q_hit1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(ifc.level),         32'd0);
        chk("t6_rst_empty", 32'(ifc.empty),         32'd1);
        chk("t6_rst_hit",   32'(ifc.q_hit1),        32'd0);
        chk("t6_rst_data",  ifc.q_data1,            32'd0);
        chk("t6_rst_addr",  32'(ifc.write_address), 32'd0);
        cyc(); rst_n = 1'b1; ifc.wr_hold = 1'b0; #2;
        chk("t6_post_empty", 32'(ifc.empty), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(); #2;
            chk("t6_no_stale_we", 32'(ifc.write_enable), 32'd0);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
